// File: rtl/nonce_dispatcher_pkg.sv
// nonce_dispatcher_pkg: shared NoC/mining definitions for the node-0 dispatcher.
//   Flit layout {valid, tail, dest[4:0], vc[1:0], data[63:0]}, credit width,
//   message constants, FSM state type and a flit builder.
//   NUM_PE defaults to 2 when the NUM_PE macro is not supplied by the build.
//   Optional feature macro: DISPATCH_TIMEOUT_EN (see nonce_dispatcher.sv).
`ifndef NUM_PE
`define NUM_PE 2
`endif

package nonce_dispatcher_pkg;
  localparam int FLIT_W       = 73;
  localparam int CREDIT_W     = 3;
  localparam int HDR_FLITS    = 10;
  localparam int RESULT_FLITS = 3;
  localparam int HDR_W        = 64 * HDR_FLITS;
  localparam logic [63:0] FOUND_BITCOIN_MSG = 64'h1;

  // flit field offsets
  localparam int FLIT_VALID_BIT = 72;
  localparam int FLIT_TAIL_BIT  = 71;
  localparam int FLIT_DEST_LSB  = 66;
  localparam int FLIT_VC_LSB    = 64;

  typedef struct packed {
    logic        valid;
    logic        tail;
    logic [4:0]  dest;
    logic [1:0]  vc;
    logic [63:0] data;
  } flit_t;

  typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_e;

  // Header flits always go out on VC0.
  function automatic flit_t mk_flit(logic tail, logic [4:0] dest, logic [63:0] data);
    flit_t f;
    f.valid = 1'b1;
    f.tail  = tail;
    f.dest  = dest;
    f.vc    = 2'b00;
    f.data  = data;
    return f;
  endfunction
endpackage

// File: rtl/nonce_dispatcher_if.sv
// nonce_dispatcher_if: header handshake, NoC inject/eject and result bundle.
//   slave  : dispatcher side (drives hdr_ready, putFlit, credits, results)
//   master : environment side (drives header, returned credits, ejected flits)
interface nonce_dispatcher_if;
  import nonce_dispatcher_pkg::*;

  logic [HDR_W-1:0]    hdr_in;
  logic                hdr_valid;
  logic                hdr_ready;
  logic                EN_putFlit;
  logic [FLIT_W-1:0]   putFlit;
  logic [CREDIT_W-1:0] credit_ret;
  logic [FLIT_W-1:0]   flit;
  logic                send_credit;
  logic [CREDIT_W-1:0] credit_in;
  logic                done_out;
  logic                found;
  logic [4:0]          found_pid;
  logic [31:0]         found_nonce;
  logic [63:0]         found_clks;
  logic                timed_out;

  modport slave (
    input  hdr_in, hdr_valid, credit_ret, flit,
    output hdr_ready, EN_putFlit, putFlit, send_credit, credit_in,
           done_out, found, found_pid, found_nonce, found_clks, timed_out
  );

  modport master (
    output hdr_in, hdr_valid, credit_ret, flit,
    input  hdr_ready, EN_putFlit, putFlit, send_credit, credit_in,
           done_out, found, found_pid, found_nonce, found_clks, timed_out
  );
endinterface

// File: rtl/nonce_dispatcher_inj_credit_counter.sv
// inj_credit_counter: up/down saturating credit counter for injection VC0.
//   clk, rst (sync, active-high), inc (credit returned), dec (flit injected),
//   has_credit: a flit may be injected this cycle.
module inj_credit_counter #(
  parameter int MAX = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic dec,
  output logic has_credit
);
  localparam int W = $clog2(MAX + 1);

  logic [W-1:0] cnt_q, cnt_d;

  // A return in the same cycle counts as available credit, so a stalled
  // sender resumes on the very cycle the credit arrives.
  assign has_credit = (cnt_q != '0) || inc;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && !dec && cnt_q != W'(MAX)) cnt_d = cnt_q + 1'b1;
    else if (dec && !inc)                cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= W'(MAX);
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/nonce_dispatcher.sv
// nonce_dispatcher: NoC node-0 master. Sends a 640-bit header as 10 flits to
//   each PE 1..NUM_PE, parses 3-flit result messages, latches the first good
//   result and broadcasts done_out.
// Ports: sys_clk, reset (sync, active-high), bus (nonce_dispatcher_if.slave).
// Optional macro DISPATCH_TIMEOUT_EN: WAIT-state watchdog driving timed_out.
module nonce_dispatcher
  import nonce_dispatcher_pkg::*;
#(
  parameter int          NUM_PE      = `NUM_PE,
  parameter int          INJ_CREDITS = 8,
  parameter logic [31:0] TIMEOUT_CYC = 32'hFFFF_FFFF
) (
  input  logic               sys_clk,
  input  logic               reset,
  nonce_dispatcher_if.slave  bus
);
  localparam logic [4:0] LAST_PE = 5'(NUM_PE);
  localparam logic [3:0] LAST_K  = 4'(HDR_FLITS - 1);

  state_e            state_q;
  logic [HDR_W-1:0]  hdr_q;
  logic [3:0]        k_q;
  logic [4:0]        pe_q, pid_q, good_cnt_q;
  logic              hdr_ready_q, en_put_q, send_credit_q, done_q, found_q;
  logic [FLIT_W-1:0] put_q;
  logic [2:0]        credit_in_q;
  logic [31:0]       nonce_q, nonce_tmp_q;
  logic [63:0]       clks_q;
  logic [1:0]        idx_q;
  logic              bad_q;
  logic              has_credit, inject, ret, ej_vld, msg_good, win;
  flit_t             ej;

  assign ej       = flit_t'(bus.flit);
  assign ej_vld   = ej.valid && (state_q != IDLE);
  assign inject   = (state_q == SEND) && has_credit;
  assign ret      = bus.credit_ret[2] && (bus.credit_ret[1:0] == 2'b00);
  assign msg_good = ej_vld && !bad_q && (idx_q == 2'd2) && ej.tail;
  // Only a result seen while traffic is live can win; DONE just drains.
  assign win      = msg_good && !found_q && (state_q == SEND || state_q == WAIT);

  inj_credit_counter #(.MAX(INJ_CREDITS)) u_cred (
    .clk(sys_clk), .rst(reset), .inc(ret), .dec(inject), .has_credit(has_credit)
  );

`ifdef DISPATCH_TIMEOUT_EN
  logic [31:0] to_cnt_q;
  logic        timed_out_q;
  logic        to_fire;
  assign to_fire = (state_q == WAIT) && (to_cnt_q == TIMEOUT_CYC - 32'd1);
  assign bus.timed_out = timed_out_q;
`else
  logic unused_cfg;
  assign unused_cfg    = ^TIMEOUT_CYC;
  assign bus.timed_out = 1'b0;
`endif

  logic unused_ej;
  assign unused_ej = ^{ej.dest, ej.vc};

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q       <= IDLE;
      hdr_q         <= '0;
      k_q           <= '0;
      pe_q          <= 5'd1;
      hdr_ready_q   <= 1'b1;
      en_put_q      <= 1'b0;
      put_q         <= '0;
      send_credit_q <= 1'b0;
      credit_in_q   <= '0;
      done_q        <= 1'b0;
      found_q       <= 1'b0;
      pid_q         <= '0;
      good_cnt_q    <= '0;
      nonce_q       <= '0;
      nonce_tmp_q   <= '0;
      clks_q        <= '0;
      idx_q         <= '0;
      bad_q         <= 1'b0;
`ifdef DISPATCH_TIMEOUT_EN
      to_cnt_q      <= '0;
      timed_out_q   <= 1'b0;
`endif
    end else begin
      en_put_q      <= 1'b0;
      put_q         <= '0;
      send_credit_q <= ej_vld;
      credit_in_q   <= ej_vld ? 3'b100 : 3'b000;

      // Result parser: any tail closes the message; a bad message is
      // swallowed until its tail.
      if (ej_vld) begin
        if (ej.tail) begin
          idx_q <= '0;
          bad_q <= 1'b0;
        end else if (!bad_q) begin
          case (idx_q)
            2'd0: if (ej.data != FOUND_BITCOIN_MSG) bad_q <= 1'b1;
                  else                              idx_q <= 2'd1;
            2'd1: begin
              nonce_tmp_q <= ej.data[31:0];
              idx_q       <= 2'd2;
            end
            default: bad_q <= 1'b1;   // clks flit without tail
          endcase
        end
      end

      if (msg_good) good_cnt_q <= good_cnt_q + 5'd1;
      if (win) begin
        found_q <= 1'b1;
        done_q  <= 1'b1;
        nonce_q <= nonce_tmp_q;
        clks_q  <= ej.data;
`ifndef DISPATCH_TIMEOUT_EN
        pid_q   <= good_cnt_q + 5'd1;
`endif
      end

      case (state_q)
        IDLE: if (bus.hdr_valid && hdr_ready_q) begin
          hdr_q       <= bus.hdr_in;
          hdr_ready_q <= 1'b0;
          k_q         <= '0;
          pe_q        <= 5'd1;
          state_q     <= SEND;
        end
        SEND: if (has_credit) begin
          en_put_q <= 1'b1;
          put_q    <= mk_flit(k_q == LAST_K, pe_q, hdr_q[{k_q, 6'b0} +: 64]);
          if (k_q == LAST_K) begin
            k_q <= '0;
            if (pe_q == LAST_PE) state_q <= (found_q || win) ? DONE : WAIT;
            else                 pe_q    <= pe_q + 5'd1;
          end else begin
            k_q <= k_q + 4'd1;
          end
        end
        WAIT: begin
          if (win) state_q <= DONE;
`ifdef DISPATCH_TIMEOUT_EN
          to_cnt_q <= to_cnt_q + 32'd1;
          if (to_fire) begin
            timed_out_q <= 1'b1;
            done_q      <= 1'b1;
            state_q     <= DONE;
          end
`endif
        end
        default: ;
      endcase
    end
  end

  assign bus.hdr_ready   = hdr_ready_q;
  assign bus.EN_putFlit  = en_put_q;
  assign bus.putFlit     = put_q;
  assign bus.send_credit = send_credit_q;
  assign bus.credit_in   = credit_in_q;
  assign bus.done_out    = done_q;
  assign bus.found       = found_q;
  assign bus.found_pid   = pid_q;
  assign bus.found_nonce = nonce_q;
  assign bus.found_clks  = clks_q;
endmodule

// File: tb/tb_nonce_dispatcher.sv
// tb_nonce_dispatcher: self-checking bench for nonce_dispatcher (NUM_PE=2,
//   INJ_CREDITS=8, TIMEOUT_CYC=100). Injected flits are checked against a
//   scoreboard queue filled when the header is offered; result messages run
//   from a vector table plus hand-written multi-cycle sequences.
module tb_nonce_dispatcher;
  import nonce_dispatcher_pkg::*;

  logic sys_clk = 1'b0;
  logic reset;
  always #5 sys_clk = ~sys_clk;

  nonce_dispatcher_if bus();

  nonce_dispatcher #(.NUM_PE(2), .INJ_CREDITS(8), .TIMEOUT_CYC(32'd100)) dut (
    .sys_clk(sys_clk), .reset(reset), .bus(bus)
  );

  typedef struct {
    int          nf;
    logic [63:0] d0, d1, d2;
    bit          ef;
    logic [31:0] en;
    logic [63:0] ec;
  } vec_t;

  int               n_cmp = 0, n_bad = 0;
  logic [FLIT_W-1:0] exp_q[$];
  int               inj_cnt = 0, cred_cnt = 0;
  bit               auto_credit = 1'b0;
  bit               rp = 1'b0;
  logic [2:0]       manual_ret = 3'b000;
  logic [HDR_W-1:0] hdr;
  vec_t             vt[4];

  task automatic chk(string nm, logic [127:0] act, logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // One cycle: wait for the falling edge, score outputs, drive credit return.
  task automatic step();
    logic [FLIT_W-1:0] e;
    bit nxt;
    @(negedge sys_clk);
    nxt = 1'b0;
    if (bus.EN_putFlit) begin
      inj_cnt++;
      e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
      chk("inj_flit", 128'(bus.putFlit), 128'(e));
      nxt = auto_credit;
    end
    if (bus.send_credit) begin
      cred_cnt++;
      chk("credit_in", 128'(bus.credit_in), 128'(3'b100));
    end
    bus.credit_ret = rp ? 3'b100 : manual_ret;
    manual_ret = 3'b000;
    rp = nxt;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.hdr_valid = 1'b0;
    bus.flit = '0;
    manual_ret = 3'b000;
    step();
    step();
    reset = 1'b0;
    bus.credit_ret = 3'b000;
    exp_q.delete();
    rp = 1'b0;
    inj_cnt = 0;
    cred_cnt = 0;
  endtask

  task automatic send_hdr();
    for (int w = 0; w < 20; w++) hdr[32*w +: 32] = $urandom;
    chk("hdr_ready_idle", 128'(bus.hdr_ready), 128'(1));
    bus.hdr_in = hdr;
    bus.hdr_valid = 1'b1;
    step();
    bus.hdr_valid = 1'b0;
    chk("hdr_ready_busy", 128'(bus.hdr_ready), 128'(0));
    for (int p = 1; p <= 2; p++)
      for (int k = 0; k < 10; k++)
        exp_q.push_back({1'b1, (k == 9), 5'(p), 2'b00, hdr[64*k +: 64]});
  endtask

  task automatic run_to_wait();
    for (int c = 0; c < 200 && exp_q.size() != 0; c++) step();
    chk("inj_all_sent", 128'(exp_q.size()), 128'(0));
  endtask

  task automatic eject(bit tail, logic [63:0] d);
    bus.flit = {1'b1, tail, 5'd0, 2'b00, d};
    step();
    bus.flit = '0;
  endtask

  task automatic eject_good(logic [31:0] nonce, logic [63:0] clks);
    eject(1'b0, 64'h1);
    eject(1'b0, {32'hA5A5_0000, nonce});
    eject(1'b1, clks);
  endtask

  initial begin
    vt[0] = '{3, 64'h1, 64'h0000_1234,           64'h99,                  1'b1, 32'h0000_1234, 64'h99};
    vt[1] = '{3, 64'h2, 64'h0000_1234,           64'h99,                  1'b0, 32'h0,         64'h0};
    vt[2] = '{3, 64'h1, 64'hDEAD_BEEF_CAFE_F00D, 64'h0123_4567_89AB_CDEF, 1'b1, 32'hCAFE_F00D, 64'h0123_4567_89AB_CDEF};
    vt[3] = '{2, 64'h1, 64'h0000_7777,           64'h0,                   1'b0, 32'h0,         64'h0};

    bus.hdr_in = '0;
    bus.credit_ret = 3'b000;
    do_reset();
    // reset values (sampled while reset is still asserted)
    reset = 1'b1;
    step();
    chk("rst_hdr_ready",   128'(bus.hdr_ready),   128'(1));
    chk("rst_EN_putFlit",  128'(bus.EN_putFlit),  128'(0));
    chk("rst_putFlit",     128'(bus.putFlit),     128'(0));
    chk("rst_send_credit", 128'(bus.send_credit), 128'(0));
    chk("rst_credit_in",   128'(bus.credit_in),   128'(0));
    chk("rst_done_out",    128'(bus.done_out),    128'(0));
    chk("rst_found",       128'(bus.found),       128'(0));
    chk("rst_found_pid",   128'(bus.found_pid),   128'(0));
    chk("rst_found_nonce", 128'(bus.found_nonce), 128'(0));
    chk("rst_found_clks",  128'(bus.found_clks),  128'(0));
    chk("rst_timed_out",   128'(bus.timed_out),   128'(0));
    reset = 1'b0;

    // ejection is ignored in IDLE
    eject(1'b0, 64'h1);
    step();
    chk("idle_no_credit", 128'(cred_cnt), 128'(0));

    // full header injection with credits returned 2 cycles later
    do_reset();
    auto_credit = 1'b1;
    send_hdr();
    run_to_wait();
    chk("inj_count_20", 128'(inj_cnt), 128'(20));
    repeat (5) step();
    chk("no_extra_inj", 128'(inj_cnt), 128'(20));

    // table-driven result messages, each in WAIT after a full injection
    foreach (vt[i]) begin
      do_reset();
      auto_credit = 1'b1;
      send_hdr();
      run_to_wait();
      cred_cnt = 0;
      eject(1'b0, vt[i].d0);
      eject(vt[i].nf == 2, vt[i].d1);
      chk($sformatf("v%0d_done_early", i), 128'(bus.done_out), 128'(0));
      if (vt[i].nf == 3) eject(1'b1, vt[i].d2);
      chk($sformatf("v%0d_found", i),    128'(bus.found),       128'(vt[i].ef));
      chk($sformatf("v%0d_done_out", i), 128'(bus.done_out),    128'(vt[i].ef));
      chk($sformatf("v%0d_nonce", i),    128'(bus.found_nonce), 128'(vt[i].en));
      chk($sformatf("v%0d_clks", i),     128'(bus.found_clks),  128'(vt[i].ec));
`ifdef DISPATCH_TIMEOUT_EN
      chk($sformatf("v%0d_pid", i),      128'(bus.found_pid),   128'(0));
`else
      chk($sformatf("v%0d_pid", i),      128'(bus.found_pid),   128'(vt[i].ef ? 1 : 0));
`endif
      step();
      chk($sformatf("v%0d_credits", i), 128'(cred_cnt), 128'(vt[i].nf));
      chk($sformatf("v%0d_timed_out", i), 128'(bus.timed_out), 128'(0));
    end

    // two good messages: only the first is latched
    do_reset();
    auto_credit = 1'b1;
    send_hdr();
    run_to_wait();
    cred_cnt = 0;
    eject_good(32'h1111, 64'h5);
    eject_good(32'h2222, 64'h6);
    step();
    chk("two_nonce",   128'(bus.found_nonce), 128'(32'h1111));
    chk("two_clks",    128'(bus.found_clks),  128'(64'h5));
    chk("two_credits", 128'(cred_cnt),        128'(6));

    // a bad message followed by a good one: parser recovers
    do_reset();
    auto_credit = 1'b1;
    send_hdr();
    run_to_wait();
    eject(1'b0, 64'h3);
    eject(1'b0, 64'h1);
    eject(1'b1, 64'h1);
    chk("bad_then_found0", 128'(bus.found), 128'(0));
    eject_good(32'hABCD, 64'h77);
    chk("recover_found", 128'(bus.found),       128'(1));
    chk("recover_nonce", 128'(bus.found_nonce), 128'(32'hABCD));

    // credit stall: 8 flits, wrong-VC return ignored, one return -> 9th next cycle
    do_reset();
    auto_credit = 1'b0;
    send_hdr();
    repeat (20) step();
    chk("stall_8", 128'(inj_cnt), 128'(8));
    manual_ret = 3'b101;
    step();
    step();
    chk("wrong_vc_ignored", 128'(inj_cnt), 128'(8));
    manual_ret = 3'b100;
    step();
    step();
    chk("ninth_next_cycle", 128'(inj_cnt), 128'(9));
    repeat (3) step();
    chk("stall_9", 128'(inj_cnt), 128'(9));

    // result arrives while SEND is still stalled; SEND then completes
    eject_good(32'hF00D, 64'h42);
    chk("early_found", 128'(bus.found),       128'(1));
    chk("early_done",  128'(bus.done_out),    128'(1));
    chk("early_nonce", 128'(bus.found_nonce), 128'(32'hF00D));
    for (int c = 0; c < 100 && exp_q.size() != 0; c++) begin
      manual_ret = 3'b100;
      step();
    end
    chk("early_send_done", 128'(exp_q.size()), 128'(0));
    repeat (4) step();
    chk("early_inj_20", 128'(inj_cnt),     128'(20));
    chk("early_clks",   128'(bus.found_clks), 128'(64'h42));

    // reset mid-SEND abandons traffic
    do_reset();
    auto_credit = 1'b1;
    send_hdr();
    repeat (4) step();
    reset = 1'b1;
    step();
    chk("midrst_EN_putFlit", 128'(bus.EN_putFlit), 128'(0));
    chk("midrst_hdr_ready",  128'(bus.hdr_ready),  128'(1));
    reset = 1'b0;
    exp_q.delete();
    inj_cnt = 0;
    repeat (5) step();
    chk("midrst_idle_no_inj", 128'(inj_cnt), 128'(0));

`ifdef DISPATCH_TIMEOUT_EN
    // watchdog fires after TIMEOUT_CYC cycles in WAIT
    begin
      int n;
      do_reset();
      auto_credit = 1'b1;
      send_hdr();
      run_to_wait();
      n = 0;
      for (int c = 0; c < 150 && !bus.timed_out; c++) begin
        step();
        n++;
      end
      chk("to_cycles",    128'(n),            128'(100));
      chk("to_timed_out", 128'(bus.timed_out), 128'(1));
      chk("to_done_out",  128'(bus.done_out),  128'(1));
      chk("to_found",     128'(bus.found),     128'(0));
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
